// File: rtl/seg7_reader.sv
// Recovers the digit shown on an active-low 7-segment bus, with glitch filtering and count-sequence checking.
// Latency: a pattern held from edge k is accepted at edge k+2+STABLE_CYCLES; all outputs are registered.
// Backpressure: none; the display bus is observed passively and every pulse lasts exactly one cycle.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int MODULUS       = 8,
    parameter int CNT_W         = 8
) (
    input  logic             CLOCK_50,
    input  logic [17:17]     V_SW,
    input  logic [0:6]       SEG_IN,
    output logic [3:0]       DIGIT,
    output logic             DIGIT_VALID,
    output logic             BLANK,
    output logic             PAT_ERR,
    output logic             SEQ_ERR,
    output logic [CNT_W-1:0] SEQ_ERR_CNT
);

    localparam int         SC_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    logic [0:6]       sync1_q, sync1_d;
    logic [0:6]       sync2_q, sync2_d;
    logic [0:6]       samp_q, samp_d;
    logic [SC_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic [0:6]       acc_q, acc_d;
    logic [3:0]       digit_q, digit_d;
    logic             digit_vld_q, digit_vld_d;
    logic             blank_q, blank_d;
    logic             pat_err_q, pat_err_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             have_prev_q, have_prev_d;
    logic [3:0]       prev_q, prev_d;

    logic             accept;
    logic             dec_hit;
    logic [3:0]       dec_dig;
    logic [4:0]       nxt_dig;

    always_comb begin
        dec_hit = 1'b1;
        dec_dig = 4'd0;
        case (samp_q)
            7'b0000001: dec_dig = 4'd0;
            7'b1001111: dec_dig = 4'd1;
            7'b0010010: dec_dig = 4'd2;
            7'b0000110: dec_dig = 4'd3;
            7'b1001100: dec_dig = 4'd4;
            7'b0100100: dec_dig = 4'd5;
            7'b0100000: dec_dig = 4'd6;
            7'b0001111: dec_dig = 4'd7;
            7'b0000000: dec_dig = 4'd8;
            7'b0000100: dec_dig = 4'd9;
            default:    dec_hit = 1'b0;
        endcase
    end

    always_comb begin
        sync1_d     = SEG_IN;
        sync2_d     = sync1_q;
        samp_d      = sync2_q;
        stab_cnt_d  = stab_cnt_q;
        acc_d       = acc_q;
        digit_d     = digit_q;
        digit_vld_d = 1'b0;
        blank_d     = blank_q;
        pat_err_d   = 1'b0;
        seq_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        nxt_dig     = ({1'b0, prev_q} + 5'd1) % 5'(MODULUS);

        if (sync2_q != samp_q)
            stab_cnt_d = '0;
        else if (stab_cnt_q != SC_W'(STABLE_CYCLES))
            stab_cnt_d = stab_cnt_q + SC_W'(1);

        // samp_q has now been seen STABLE_CYCLES times in a row
        accept = (stab_cnt_q == SC_W'(STABLE_CYCLES - 1)) && (samp_q != acc_q);

        if (accept) begin
            acc_d = samp_q;
            if (dec_hit) begin
                digit_d     = dec_dig;
                digit_vld_d = 1'b1;
                blank_d     = 1'b0;
                if (have_prev_q && dec_dig != 4'd0 &&
                    (int'(dec_dig) >= MODULUS || {1'b0, dec_dig} != nxt_dig)) begin
                    seq_err_d = 1'b1;
                    if (err_cnt_q != '1)
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                prev_d      = dec_dig;
                have_prev_d = 1'b1;
            end else if (samp_q == SEG_BLANK) begin
                blank_d     = 1'b1;
                have_prev_d = 1'b0;
            end else begin
                pat_err_d   = 1'b1;
                have_prev_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (V_SW[17]) begin
            sync1_q     <= SEG_BLANK;
            sync2_q     <= SEG_BLANK;
            samp_q      <= SEG_BLANK;
            stab_cnt_q  <= '0;
            acc_q       <= SEG_BLANK;
            digit_q     <= 4'd0;
            digit_vld_q <= 1'b0;
            blank_q     <= 1'b1;
            pat_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            have_prev_q <= 1'b0;
            prev_q      <= 4'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            samp_q      <= samp_d;
            stab_cnt_q  <= stab_cnt_d;
            acc_q       <= acc_d;
            digit_q     <= digit_d;
            digit_vld_q <= digit_vld_d;
            blank_q     <= blank_d;
            pat_err_q   <= pat_err_d;
            seq_err_q   <= seq_err_d;
            err_cnt_q   <= err_cnt_d;
            have_prev_q <= have_prev_d;
            prev_q      <= prev_d;
        end
    end

    assign DIGIT       = digit_q;
    assign DIGIT_VALID = digit_vld_q;
    assign BLANK       = blank_q;
    assign PAT_ERR     = pat_err_q;
    assign SEQ_ERR     = seq_err_q;
    assign SEQ_ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: table of display patterns with hand-derived expectations,
// scoreboard of expected accept events checked by a negedge monitor.
module tb_seg7_reader;

    localparam int S = 4;

    logic         clk = 1'b0;
    logic [17:17] v_sw;
    logic [0:6]   seg_in;
    logic [3:0]   digit;
    logic         digit_valid, blank, pat_err, seq_err;
    logic [7:0]   seq_err_cnt;

    seg7_reader #(.STABLE_CYCLES(S), .MODULUS(8), .CNT_W(8)) dut (
        .CLOCK_50   (clk),
        .V_SW       (v_sw),
        .SEG_IN     (seg_in),
        .DIGIT      (digit),
        .DIGIT_VALID(digit_valid),
        .BLANK      (blank),
        .PAT_ERR    (pat_err),
        .SEQ_ERR    (seq_err),
        .SEQ_ERR_CNT(seq_err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] dig;
        logic       seq;
        logic       pe;
        logic [7:0] cnt;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [0:6] pat;
        int         hold;
        bit         evt;
        logic [3:0] dig;
        bit         seq;
        bit         pe;
        logic [7:0] cnt;
        bit         blank_after;
        logic [3:0] dig_after;
    } row_t;
    row_t tbl[$];

    logic [0:6] pats [0:9];
    logic [0:6] pat_blank;
    logic [0:6] pat_bad;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!v_sw[17] && (digit_valid || pat_err || seq_err)) begin
            if (sbq.size() == 0) begin
                check("unexpected_event", {29'd0, digit_valid, pat_err, seq_err}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("evt_cycle", cyc, e.cyc);
                check("evt_digit_valid", digit_valid, !e.pe);
                check("evt_pat_err", pat_err, e.pe);
                check("evt_seq_err", seq_err, e.seq);
                check("evt_digit", digit, e.dig);
                check("evt_seq_err_cnt", seq_err_cnt, e.cnt);
            end
        end
    end

    task automatic show(input logic [0:6] pat, input int hold, input bit evt,
                        input logic [3:0] dig, input bit seq, input bit pe, input logic [7:0] cnt);
        exp_t e;
        if (evt) begin
            e.cyc = cyc + 3 + S;
            e.dig = dig;
            e.seq = seq;
            e.pe  = pe;
            e.cnt = cnt;
            sbq.push_back(e);
        end
        seg_in = pat;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    function automatic row_t mk(input logic [0:6] pat, input int hold, input bit evt,
                                input logic [3:0] dig, input bit seq, input bit pe,
                                input logic [7:0] cnt, input bit bl, input logic [3:0] da);
        row_t r;
        r.pat = pat; r.hold = hold; r.evt = evt; r.dig = dig; r.seq = seq; r.pe = pe;
        r.cnt = cnt; r.blank_after = bl; r.dig_after = da;
        return r;
    endfunction

    initial begin
        pats[0] = 7'b0000001; pats[1] = 7'b1001111; pats[2] = 7'b0010010;
        pats[3] = 7'b0000110; pats[4] = 7'b1001100; pats[5] = 7'b0100100;
        pats[6] = 7'b0100000; pats[7] = 7'b0001111; pats[8] = 7'b0000000;
        pats[9] = 7'b0000100;
        pat_blank = 7'b1111111;
        pat_bad   = 7'b1111110;

        // count 0..7 then wrap to 0
        tbl.push_back(mk(pats[0], 10, 1, 0, 0, 0, 0, 0, 0));
        for (int d = 1; d < 8; d++)
            tbl.push_back(mk(pats[d], 10, 1, 4'(d), 0, 0, 0, 0, 4'(d)));
        tbl.push_back(mk(pats[0], 10, 1, 0, 0, 0, 0, 0, 0));
        // blank breaks the run, then 2 -> 5 -> 9 are out of sequence
        tbl.push_back(mk(pat_blank, 10, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(pats[2], 10, 1, 2, 0, 0, 0, 0, 2));
        tbl.push_back(mk(pats[5], 10, 1, 5, 1, 0, 1, 0, 5));
        tbl.push_back(mk(pats[9], 10, 1, 9, 1, 0, 2, 0, 9));
        // glitches of 8 over a steady 3, then a real 8 (8 >= modulus after 3)
        tbl.push_back(mk(pat_blank, 10, 0, 0, 0, 0, 0, 1, 9));
        tbl.push_back(mk(pats[3], 10, 1, 3, 0, 0, 2, 0, 3));
        tbl.push_back(mk(pats[8], 1, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(pats[3], 10, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(pats[8], 2, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(pats[3], 10, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(pats[8], 3, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(pats[3], 10, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(pats[8], 10, 1, 8, 1, 0, 3, 0, 8));
        // illegal pattern, then a digit that must not flag a sequence error
        tbl.push_back(mk(pat_bad, 10, 1, 8, 0, 1, 3, 0, 8));
        tbl.push_back(mk(pats[4], 10, 1, 4, 0, 0, 3, 0, 4));

        v_sw   = 1'b1;
        seg_in = pat_blank;
        repeat (3) @(posedge clk);
        #1;
        v_sw = 1'b0;
        check("rst_digit", digit, 4'd0);
        check("rst_blank", blank, 1'b1);
        check("rst_pulses", {digit_valid, pat_err, seq_err}, 3'b000);
        check("rst_cnt", seq_err_cnt, 8'd0);
        show(pat_blank, 20, 0, 0, 0, 0, 0);
        check("idle_digit", digit, 4'd0);
        check("idle_blank", blank, 1'b1);
        check("idle_cnt", seq_err_cnt, 8'd0);

        foreach (tbl[i]) begin
            show(tbl[i].pat, tbl[i].hold, tbl[i].evt, tbl[i].dig, tbl[i].seq, tbl[i].pe, tbl[i].cnt);
            check($sformatf("row%0d_blank", i), blank, tbl[i].blank_after);
            check($sformatf("row%0d_digit", i), digit, tbl[i].dig_after);
        end

        // alternating 2/5 breaks the sequence every time; count saturates
        for (int i = 0; i < 300; i++) begin
            int c;
            c = (3 + i + 1 > 255) ? 255 : 3 + i + 1;
            if (i % 2 == 0) show(pats[2], 6, 1, 2, 1, 0, 8'(c));
            else            show(pats[5], 6, 1, 5, 1, 0, 8'(c));
        end
        repeat (10) @(posedge clk);
        #1;
        check("sat_cnt", seq_err_cnt, 8'd255);
        check("sat_queue_drained", sbq.size(), 0);

        // reset while a 7 is part-way through the filter
        seg_in = pats[7];
        repeat (2) @(posedge clk);
        #1;
        v_sw = 1'b1;
        @(posedge clk);
        #1;
        v_sw = 1'b0;
        check("midrst_digit", digit, 4'd0);
        check("midrst_blank", blank, 1'b1);
        check("midrst_pulses", {digit_valid, pat_err, seq_err}, 3'b000);
        check("midrst_cnt", seq_err_cnt, 8'd0);
        @(posedge clk);
        #1;
        show(pat_blank, 20, 0, 0, 0, 0, 0);
        check("dropped_digit", digit, 4'd0);
        check("dropped_blank", blank, 1'b1);

        show(pats[3], 10, 1, 3, 0, 0, 0);
        check("post_rst_digit", digit, 4'd3);
        check("post_rst_blank", blank, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("final_queue_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
